// File: rtl/wb_arbiter.sv
// ============================================================================
// wb_arbiter : register-file write-back arbiter (ALU + long-latency FIFO)
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_arbiter #(
  parameter int DEPTH  = 4,
  parameter int STARVE = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_alu_v,
  input  logic [4:0]  i_alu_rd,
  input  logic [31:0] i_alu_d,
  output logic        o_alu_rdy,
  input  logic        i_mem_v,
  input  logic [4:0]  i_mem_rd,
  input  logic [31:0] i_mem_d,
  output logic        o_mem_rdy,
  output logic        o_we,
  output logic [4:0]  o_aw,
  output logic [31:0] o_d,
  output logic [31:0] o_pend
);

  localparam int unsigned      c_PTR_W    = $clog2(DEPTH);
  localparam int unsigned      c_ST_W     = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
  localparam logic [c_PTR_W:0] c_CNT_ONE  = (c_PTR_W+1)'(1);
  localparam logic [c_PTR_W:0] c_CNT_FULL = (c_PTR_W+1)'(DEPTH);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
  localparam logic [c_ST_W-1:0]  c_ST_MAX  = c_ST_W'(STARVE);
  localparam logic [c_ST_W-1:0]  c_ST_ONE  = c_ST_W'(1);

  logic [4:0]         r_rd  [DEPTH];
  logic [31:0]        r_dat [DEPTH];
  logic [c_PTR_W-1:0] r_wp;
  logic [c_PTR_W-1:0] r_rp;
  logic [c_PTR_W:0]   r_cnt;
  logic [c_ST_W-1:0]  r_starve;
  logic               r_we;
  logic [4:0]         r_aw;
  logic [31:0]        r_d;

  logic [DEPTH-1:0]   w_slot_v;
  logic [DEPTH-1:0]   w_hit;
  logic               w_empty;
  logic               w_full;
  logic               w_waw;
  logic               w_fifo_pri;
  logic               w_alu_wr;
  logic               w_pop;
  logic               w_push;
  logic [31:0]        w_pend;

  // A slot is live when its distance from the read pointer is below the count.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [c_PTR_W-1:0] w_off;
      assign w_off        = c_PTR_W'(gi) - r_rp;
      assign w_slot_v[gi] = ({1'b0, w_off} < r_cnt);
      assign w_hit[gi]    = w_slot_v[gi] && (r_rd[gi] == i_alu_rd);
    end
  endgenerate

  assign w_empty    = (r_cnt == '0);
  assign w_full     = (r_cnt == c_CNT_FULL);
  assign w_waw      = (i_alu_rd != 5'd0) && (|w_hit);
  assign w_fifo_pri = !w_empty && (w_full || (r_starve == c_ST_MAX) || w_waw);
  assign o_alu_rdy  = !w_fifo_pri && !w_waw;
  assign o_mem_rdy  = !w_full;
  assign w_alu_wr   = i_alu_v && (i_alu_rd != 5'd0) && !w_fifo_pri;
  assign w_pop      = !w_empty && !w_alu_wr;
  assign w_push     = i_mem_v && !w_full && (i_mem_rd != 5'd0);

  always_comb begin
    w_pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_slot_v[i]) w_pend[r_rd[i]] = 1'b1;
    end
    if (r_we) w_pend[r_aw] = 1'b1;
    w_pend[0] = 1'b0;
  end
  assign o_pend = w_pend;

  // Storage needs no reset: only slots covered by the count are ever observed.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_rd[r_wp]  <= i_mem_rd;
      r_dat[r_wp] <= i_mem_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wp     <= '0;
      r_rp     <= '0;
      r_cnt    <= '0;
      r_starve <= '0;
      r_we     <= 1'b0;
      r_aw     <= '0;
      r_d      <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + c_PTR_ONE;
      if (w_pop)  r_rp <= r_rp + c_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + c_CNT_ONE;
        2'b01:   r_cnt <= r_cnt - c_CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase

      if (w_pop || w_empty)
        r_starve <= '0;
      else if (w_alu_wr && (r_starve != c_ST_MAX))
        r_starve <= r_starve + c_ST_ONE;

      r_we <= w_pop || w_alu_wr;
      if (w_pop) begin
        r_aw <= r_rd[r_rp];
        r_d  <= r_dat[r_rp];
      end else if (w_alu_wr) begin
        r_aw <= i_alu_rd;
        r_d  <= i_alu_d;
      end
    end
  end

  assign o_we = r_we;
  assign o_aw = r_aw;
  assign o_d  = r_d;

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// ============================================================================
// tb_wb_arbiter : randomized bench for wb_arbiter against a queue-based model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_wb_arbiter;

  localparam int DEPTH  = 4;
  localparam int STARVE = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_v;
  logic [4:0]  alu_rd;
  logic [31:0] alu_d;
  logic        alu_rdy;
  logic        mem_v;
  logic [4:0]  mem_rd;
  logic [31:0] mem_d;
  logic        mem_rdy;
  logic        we;
  logic [4:0]  aw;
  logic [31:0] d;
  logic [31:0] pend;

  always #5 clk = ~clk;

  wb_arbiter #(.DEPTH(DEPTH), .STARVE(STARVE)) u_dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_alu_v  (alu_v),
    .i_alu_rd (alu_rd),
    .i_alu_d  (alu_d),
    .o_alu_rdy(alu_rdy),
    .i_mem_v  (mem_v),
    .i_mem_rd (mem_rd),
    .i_mem_d  (mem_d),
    .o_mem_rdy(mem_rdy),
    .o_we     (we),
    .o_aw     (aw),
    .o_d      (d),
    .o_pend   (pend)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  // Reference model: queued results in arrival order plus the visible write stage.
  ent_t        q[$];
  int          starve;
  logic        m_we;
  logic [4:0]  m_aw;
  logic [31:0] m_d;
  logic        hold_a;
  logic        hold_m;
  int          checks = 0;
  int          errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    starve = 0;
    m_we   = 1'b0;
    m_aw   = '0;
    m_d    = '0;
    hold_a = 1'b0;
    hold_m = 1'b0;
  endtask

  // One clock: drive inputs (honouring producer hold), check, advance model.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    logic        waw, fpri, e_ardy, e_mrdy, popped, alu_w;
    logic [31:0] e_pend;
    int          n;
    ent_t        e;
    @(negedge clk);
    if (!hold_a) begin alu_v = av; alu_rd = ard; alu_d = ad; end
    if (!hold_m) begin mem_v = mv; mem_rd = mrd; mem_d = md; end
    #1;
    n   = q.size();
    waw = 1'b0;
    for (int i = 0; i < n; i++) if (alu_rd != 0 && q[i].rd == alu_rd) waw = 1'b1;
    fpri   = (n > 0) && (n == DEPTH || starve == STARVE || waw);
    e_ardy = !fpri && !waw;
    e_mrdy = (n < DEPTH);
    e_pend = '0;
    for (int i = 0; i < n; i++) e_pend[q[i].rd] = 1'b1;
    if (m_we) e_pend[m_aw] = 1'b1;
    e_pend[0] = 1'b0;

    check_eq("alu_rdy", {31'd0, alu_rdy}, {31'd0, e_ardy});
    check_eq("mem_rdy", {31'd0, mem_rdy}, {31'd0, e_mrdy});
    check_eq("we",      {31'd0, we},      {31'd0, m_we});
    check_eq("aw",      {27'd0, aw},      {27'd0, m_aw});
    check_eq("d",       d,                m_d);
    check_eq("pend",    pend,             e_pend);

    hold_a = alu_v && !e_ardy;
    hold_m = mem_v && !e_mrdy;

    popped = 1'b0;
    alu_w  = 1'b0;
    if (fpri) begin
      e = q.pop_front(); m_we = 1'b1; m_aw = e.rd; m_d = e.d; popped = 1'b1;
    end else if (alu_v && alu_rd != 0) begin
      m_we = 1'b1; m_aw = alu_rd; m_d = alu_d; alu_w = 1'b1;
    end else if (n > 0) begin
      e = q.pop_front(); m_we = 1'b1; m_aw = e.rd; m_d = e.d; popped = 1'b1;
    end else begin
      m_we = 1'b0;
    end
    if (popped || n == 0) starve = 0;
    else if (alu_w && starve < STARVE) starve++;
    if (mem_v && n < DEPTH && mem_rd != 0) begin
      e.rd = mem_rd; e.d = mem_d; q.push_back(e);
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; alu_v = 1'b0; mem_v = 1'b0;
    #1;
    check_eq("rst_we",      {31'd0, we},      32'd0);
    check_eq("rst_pend",    pend,             32'd0);
    check_eq("rst_mem_rdy", {31'd0, mem_rdy}, 32'd1);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int k;
    rst = 1'b1;
    alu_v = 1'b0; alu_rd = '0; alu_d = '0;
    mem_v = 1'b0; mem_rd = '0; mem_d = '0;
    model_clear();
    #12;
    check_eq("init_we",      {31'd0, we},      32'd0);
    check_eq("init_aw",      {27'd0, aw},      32'd0);
    check_eq("init_d",       d,                32'd0);
    check_eq("init_pend",    pend,             32'd0);
    check_eq("init_mem_rdy", {31'd0, mem_rdy}, 32'd1);
    rst = 1'b0;

    // ALU only, then MEM only
    step(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
    idle(2);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hDEADBEEF);
    idle(3);

    // Fill FIFO with rd 1..4 while the ALU streams rd 9
    k = 1;
    for (int c = 0; c < 16; c++) begin
      step(1'b1, 5'd9, 32'h900 + c, k <= 4, 5'(k), 32'h100 + k);
      if (mem_v && !hold_m && k <= 4) k++;
    end
    idle(6);

    // WAW: queued rd 6 must be written before the ALU's rd 6
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'hAAAA6666);
    for (int c = 0; c < 4; c++) step(1'b1, 5'd6, 32'hBBBB6666, 1'b0, 5'd0, 32'd0);
    idle(2);

    // x0 writes from both sources are dropped
    step(1'b1, 5'd0, 32'h5, 1'b1, 5'd0, 32'h6);
    idle(2);

    // Reset with three entries queued behind a busy ALU
    for (int c = 0; c < 3; c++)
      step(1'b1, 5'd9, 32'hC00 + c, 1'b1, 5'(11 + c), 32'hD00 + c);
    check_eq("queued_before_rst", q.size(), 32'd3);
    do_reset();
    idle(3);

    // Randomized traffic over a small register range to provoke WAW and fills
    for (int c = 0; c < 600; c++) begin
      if (c == 300) do_reset();
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom);
    end
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-back arbiter that owns the register file's single write port (WE/AW/D).
- Merges single-cycle ALU results with multi-cycle load/mul-div results, which are buffered in a small FIFO.
- Arbitrates the two sources onto one registered write per cycle.
- Exports a pending-write vector so decode can stall on RAW hazards against queued results.

Parameters:
- DEPTH, 4: number of entries in the long-latency result FIFO (power of 2, at least 2).
- STARVE, 3: maximum consecutive ALU grants while the FIFO is non-empty before the FIFO is forced to win.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- ALU_V  in  1  ALU result valid.
- ALU_RD  in  5  ALU destination register.
- ALU_D  in  32  ALU result.
- ALU_RDY  out  1  ALU result consumed this cycle; combinational.
- MEM_V  in  1  long-latency result valid.
- MEM_RD  in  5  long-latency destination register.
- MEM_D  in  32  long-latency result.
- MEM_RDY  out  1  FIFO can accept; combinational from registered count.
- WE  out  1  register file write enable; registered.
- AW  out  5  register file write address; registered.
- D  out  32  register file write data; registered.
- PEND  out  32  bit r set when a write to r is queued or in the output stage; combinational from state.

Behaviour:
- Reset (async, RST=1): WE=0, AW=0, D=0, FIFO empty (count=0, pointers=0), starve counter=0. PEND=0, MEM_RDY=1.
- Reset asserted mid-operation discards all queued entries; nothing is written.
- Handshake rules:
  - A transfer occurs when V && RDY in the same cycle.
  - The producer holds RD/D stable while V=1 && RDY=0.
- MEM_RDY = (count < DEPTH). Push and pop may occur in the same cycle; count is unchanged in that case.
- x0 handling: accepted transfers with RD==0 are dropped.
  - Not enqueued, no WE, no effect on PEND.
  - RDY still follows the normal rules.
- WAW ordering: if ALU_RD!=0 and any valid FIFO entry has rd==ALU_RD, then ALU_RDY=0.
- fifo_pri is true when the FIFO is non-empty and any of these holds:
  - count==DEPTH;
  - starve counter==STARVE;
  - the WAW block is active.
- ALU_RDY = !fifo_pri && !WAW-block.
- Write-stage selection each cycle, in priority order:
  - fifo_pri: pop the FIFO head.
  - else ALU_V && ALU_RD!=0: take the ALU.
  - else FIFO non-empty: pop the head.
  - else no write.
- Output stage: on the next edge, WE=1 with AW/D from the selected source; otherwise WE=0. AW and D hold their last value when WE=0.
- Latency:
  - ALU accepted at cycle n: WE at n+1.
  - MEM accepted at cycle n with an empty FIFO and no competing ALU: popped at n+1, WE at n+2.
- Starve counter:
  - +1 on each ALU grant while the FIFO is non-empty, saturating at STARVE.
  - Cleared on any FIFO pop and whenever the FIFO is empty.
- PEND[r] = OR over valid FIFO entries of (rd==r), OR (WE && AW==r). PEND[0] is always 0.
- FIFO pointers wrap modulo DEPTH. Count width is log2(DEPTH)+1.
- No data is ever lost or reordered per destination register.

Test Plan:
- ALU only: ALU_V=1, RD=5, D=0x1234 at cycle 1 -> ALU_RDY=1, and at cycle 2 WE=1, AW=5, D=0x1234. PEND[5]=1 during cycle 2 only.
- MEM only: MEM_V=1, RD=7, D=0xDEADBEEF, ALU idle -> PEND[7]=1 from the next cycle, WE=1 with AW=7 two cycles after acceptance.
- Fill and priority: push 4 MEM entries (RD 1-4) while ALU_V=1 with RD=9.
  - Full FIFO -> MEM_RDY=0 and ALU_RDY=0 until a pop.
  - After STARVE=3 ALU grants, one pop is forced.
  - All four MEM writes and all ALU writes appear in order, none lost.
- WAW block: queue MEM RD=6, then ALU_V with RD=6 -> ALU_RDY=0 until the MEM RD=6 entry is popped. The D=MEM value is written before the ALU value.
- x0 and reset: ALU RD=0 and MEM RD=0 -> both RDY=1, no WE, PEND stays 0. Assert RST with 3 queued entries -> WE=0 and PEND=0 immediately, MEM_RDY=1, no stale writes after release.
